// File: rtl/conv_pool_if.sv
// Handshake bundle between the conv/pool scheduler and its surrounding datapath.
// master = scheduler side, slave = stream source / MAC / pooling side.
interface conv_pool_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              clr;
   logic              in_valid;
   logic              ifm_we;
   logic [ADDR_W-1:0] ifm_waddr;
   logic              w_we;
   logic [3:0]        w_waddr;
   logic              conv_go;
   logic [ADDR_W-1:0] conv_base;
   logic [ADDR_W-1:0] ofm_idx;
   logic              conv_done;
   logic              pool_go;
   logic [ADDR_W-1:0] pool_base;
   logic              pool_done;
   logic              busy;
   logic              frame_done;
   logic              err_overrun;

   modport master (
      input  clr, in_valid, conv_done, pool_done,
      output ifm_we, ifm_waddr, w_we, w_waddr,
             conv_go, conv_base, ofm_idx,
             pool_go, pool_base,
             busy, frame_done, err_overrun
   );

   modport slave (
      output clr, in_valid, conv_done, pool_done,
      input  ifm_we, ifm_waddr, w_we, w_waddr,
             conv_go, conv_base, ofm_idx,
             pool_go, pool_base,
             busy, frame_done, err_overrun
   );
endinterface

// File: rtl/conv_pool_scheduler.sv
// Control sequencer for the IFM load, 3x3 conv window issue and 2x2 max-pool issue.
// Generates buffer addresses, go strobes and frame status; no pixel arithmetic.
module conv_pool_scheduler #(
   parameter int unsigned IMG_W  = 14,
   parameter int unsigned K      = 3,
   parameter int unsigned ADDR_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   conv_pool_if.master   bus
);

   localparam int unsigned OUT_W = IMG_W - K + 1;
   localparam int unsigned NCONV = OUT_W * OUT_W;
   localparam int unsigned PW    = OUT_W / 2;
   localparam int unsigned NPOOL = PW * PW;
   localparam int unsigned NPIX  = IMG_W * IMG_W;
   localparam int unsigned NW    = K * K;
   localparam int unsigned CW    = $clog2(OUT_W + 1);
   localparam int unsigned PCW   = $clog2(PW + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CONV_ISSUE,
      S_CONV_WAIT,
      S_POOL_ISSUE,
      S_POOL_WAIT,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
   logic [CW-1:0]     crow_q, crow_d, ccol_q, ccol_d;
   logic [PCW-1:0]    prow_q, prow_d, pcol_q, pcol_d;
   logic              err_q, err_d;

   logic              conv_go_q, pool_go_q, busy_q, frame_done_q;
   logic [ADDR_W-1:0] conv_base_q, ofm_idx_q, pool_base_q;

   logic              ifm_we_c;
   logic              in_load_c;

   // Stream writes are only accepted while idle or loading and within the image.
   assign in_load_c = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign ifm_we_c  = bus.in_valid && in_load_c && (32'(load_cnt_q) < NPIX);

   assign bus.ifm_we      = ifm_we_c;
   assign bus.ifm_waddr   = load_cnt_q;
   assign bus.w_we        = ifm_we_c && (32'(load_cnt_q) < NW);
   assign bus.w_waddr     = load_cnt_q[3:0];
   assign bus.conv_go     = conv_go_q;
   assign bus.conv_base   = conv_base_q;
   assign bus.ofm_idx     = ofm_idx_q;
   assign bus.pool_go     = pool_go_q;
   assign bus.pool_base   = pool_base_q;
   assign bus.busy        = busy_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.err_overrun = err_q;

   // Next-state and counter update.
   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      crow_d     = crow_q;
      ccol_d     = ccol_q;
      prow_d     = prow_q;
      pcol_d     = pcol_q;
      err_d      = err_q;

      if (bus.clr) begin
         state_d    = S_IDLE;
         load_cnt_d = '0;
         crow_d     = '0;
         ccol_d     = '0;
         prow_d     = '0;
         pcol_d     = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  state_d    = S_LOAD;
                  load_cnt_d = ADDR_W'(1);
                  err_d      = 1'b0;
               end
            end
            S_LOAD: begin
               if (bus.in_valid) begin
                  if (32'(load_cnt_q) == NPIX - 1) begin
                     state_d    = S_CONV_ISSUE;
                     load_cnt_d = '0;
                  end else begin
                     load_cnt_d = load_cnt_q + ADDR_W'(1);
                  end
               end
            end
            S_CONV_ISSUE: begin
               state_d = S_CONV_WAIT;
            end
            S_CONV_WAIT: begin
               if (bus.conv_done) begin
                  if (32'(ofm_idx_q) == NCONV - 1) begin
                     state_d = S_POOL_ISSUE;
                     crow_d  = '0;
                     ccol_d  = '0;
                  end else begin
                     state_d = S_CONV_ISSUE;
                     if (32'(ccol_q) == OUT_W - 1) begin
                        ccol_d = '0;
                        crow_d = crow_q + CW'(1);
                     end else begin
                        ccol_d = ccol_q + CW'(1);
                     end
                  end
               end
            end
            S_POOL_ISSUE: begin
               state_d = S_POOL_WAIT;
            end
            S_POOL_WAIT: begin
               if (bus.pool_done) begin
                  if ((32'(prow_q) * PW + 32'(pcol_q)) == NPOOL - 1) begin
                     state_d = S_DONE;
                     prow_d  = '0;
                     pcol_d  = '0;
                  end else begin
                     state_d = S_POOL_ISSUE;
                     if (32'(pcol_q) == PW - 1) begin
                        pcol_d = '0;
                        prow_d = prow_q + PCW'(1);
                     end else begin
                        pcol_d = pcol_q + PCW'(1);
                     end
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase

         // Stream data arriving while the frame is being processed is dropped and flagged.
         if (bus.in_valid && !in_load_c) begin
            err_d = 1'b1;
         end
      end
   end

   // State, counters and Moore-decoded outputs, all registered from the next values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         load_cnt_q   <= '0;
         crow_q       <= '0;
         ccol_q       <= '0;
         prow_q       <= '0;
         pcol_q       <= '0;
         err_q        <= 1'b0;
         conv_go_q    <= 1'b0;
         pool_go_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         conv_base_q  <= '0;
         ofm_idx_q    <= '0;
         pool_base_q  <= '0;
      end else begin
         state_q      <= state_d;
         load_cnt_q   <= load_cnt_d;
         crow_q       <= crow_d;
         ccol_q       <= ccol_d;
         prow_q       <= prow_d;
         pcol_q       <= pcol_d;
         err_q        <= err_d;
         conv_go_q    <= (state_d == S_CONV_ISSUE);
         pool_go_q    <= (state_d == S_POOL_ISSUE);
         busy_q       <= (state_d != S_IDLE);
         frame_done_q <= (state_d == S_DONE);
         conv_base_q  <= ADDR_W'(32'(crow_d) * IMG_W + 32'(ccol_d));
         ofm_idx_q    <= ADDR_W'(32'(crow_d) * OUT_W + 32'(ccol_d));
         pool_base_q  <= ADDR_W'(2 * OUT_W * 32'(prow_d) + 2 * 32'(pcol_d));
      end
   end

endmodule

// File: tb/tb_conv_pool_scheduler.sv
// Scoreboard bench for conv_pool_scheduler: stimulus queues expected addresses and strobes,
// a negedge monitor pops and compares whenever the scheduler presents them.
module tb_conv_pool_scheduler;

   localparam int IMG_W  = 14;
   localparam int K      = 3;
   localparam int ADDR_W = 8;
   localparam int OUT_W  = 12;
   localparam int NCONV  = 144;
   localparam int PW     = 6;
   localparam int NPOOL  = 36;
   localparam int NPIX   = 196;

   localparam int P_BUSY   = 0;
   localparam int P_ERR    = 1;
   localparam int P_CONVGO = 2;
   localparam int P_ALL    = 3;
   localparam int P_QCONV  = 4;
   localparam int P_QPOOL  = 5;
   localparam int P_QIFM   = 6;
   localparam int P_QW     = 7;
   localparam int P_QFD    = 8;

   typedef struct { int base; int idx; int gap; } conv_t;
   typedef struct { int base; int gap; }          pool_t;
   typedef struct { int cyc;  int err; }          fd_t;
   typedef struct { string name; int kind; int exp; } probe_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   int     exp_ifm[$];
   int     exp_w[$];
   conv_t  exp_conv[$];
   pool_t  exp_pool[$];
   fd_t    exp_fd[$];
   probe_t probes[$];

   int n_checks = 0;
   int n_fail   = 0;
   int last_conv = 0;
   int last_pool = 0;

   int clat = 1;
   int plat = 1;
   bit hold_mode = 1'b0;

   conv_pool_if #(.ADDR_W(ADDR_W)) bus ();

   conv_pool_scheduler #(
      .IMG_W (IMG_W),
      .K     (K),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sig(input int k);
      case (k)
         P_BUSY:   return int'(bus.busy);
         P_ERR:    return int'(bus.err_overrun);
         P_CONVGO: return int'(bus.conv_go);
         P_ALL:    return int'({bus.ifm_we, |bus.ifm_waddr, bus.w_we, |bus.w_waddr,
                                bus.conv_go, |bus.conv_base, |bus.ofm_idx, bus.pool_go,
                                |bus.pool_base, bus.busy, bus.frame_done, bus.err_overrun});
         P_QCONV:  return exp_conv.size();
         P_QPOOL:  return exp_pool.size();
         P_QIFM:   return exp_ifm.size();
         P_QW:     return exp_w.size();
         P_QFD:    return exp_fd.size();
         default:  return -1;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_probe(input string name, input int kind, input int exp);
      probe_t p;
      p.name = name;
      p.kind = kind;
      p.exp  = exp;
      probes.push_back(p);
   endtask

   // Monitor: probes first (queue sizes must be read before this edge's pops), then streams.
   always @(negedge clk) begin : monitor
      probe_t pr;
      conv_t  ce;
      pool_t  pe;
      fd_t    fe;
      while (probes.size() > 0) begin
         pr = probes.pop_front();
         check(pr.name, sig(pr.kind), pr.exp);
      end
      if (bus.ifm_we) begin
         if (exp_ifm.size() == 0) check("ifm_we spurious", int'(bus.ifm_we), 0);
         else                     check("ifm_waddr", int'(bus.ifm_waddr), exp_ifm.pop_front());
      end
      if (bus.w_we) begin
         if (exp_w.size() == 0) check("w_we spurious", int'(bus.w_we), 0);
         else                   check("w_waddr", int'(bus.w_waddr), exp_w.pop_front());
      end
      if (bus.conv_go) begin
         if (exp_conv.size() == 0) check("conv_go spurious", int'(bus.conv_go), 0);
         else begin
            ce = exp_conv.pop_front();
            check("conv_base", int'(bus.conv_base), ce.base);
            check("ofm_idx", int'(bus.ofm_idx), ce.idx);
            if (ce.gap != 0) check("conv_go spacing", cyc - last_conv, ce.gap);
         end
         last_conv = cyc;
      end
      if (bus.pool_go) begin
         if (exp_pool.size() == 0) check("pool_go spurious", int'(bus.pool_go), 0);
         else begin
            pe = exp_pool.pop_front();
            check("pool_base", int'(bus.pool_base), pe.base);
            if (pe.gap != 0) check("pool_go spacing", cyc - last_pool, pe.gap);
         end
         last_pool = cyc;
      end
      if (bus.frame_done) begin
         if (exp_fd.size() == 0) check("frame_done spurious", int'(bus.frame_done), 0);
         else begin
            fe = exp_fd.pop_front();
            check("frame_done cycle", cyc, fe.cyc);
            check("err_overrun at done", int'(bus.err_overrun), fe.err);
         end
      end
   end

   // MAC / pooling responder with programmable latency counted from the go cycle.
   initial begin : responder
      int   ccnt;
      int   pcnt;
      logic cd;
      logic pd;
      ccnt = 0;
      pcnt = 0;
      bus.conv_done = 1'b0;
      bus.pool_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cd = 1'b0;
         pd = 1'b0;
         if (ccnt > 0) begin
            ccnt--;
            if (ccnt == 0) cd = 1'b1;
         end
         if (pcnt > 0) begin
            pcnt--;
            if (pcnt == 0) pd = 1'b1;
         end
         if (bus.conv_go) begin
            ccnt = clat;
            if (hold_mode) cd = 1'b1;
         end
         if (bus.pool_go) pcnt = plat;
         bus.conv_done = cd;
         bus.pool_done = pd;
      end
   end

   task automatic push_frame(input int n_conv, input int n_pool, input int cgap, input int pgap);
      conv_t c;
      pool_t p;
      for (int i = 0; i < n_conv; i++) begin
         c.base = (i / OUT_W) * IMG_W + (i % OUT_W);
         c.idx  = i;
         c.gap  = (i == 0) ? 0 : cgap;
         exp_conv.push_back(c);
      end
      for (int i = 0; i < n_pool; i++) begin
         p.base = 2 * (i / PW) * OUT_W + 2 * (i % PW);
         p.gap  = (i == 0) ? 0 : pgap;
         exp_pool.push_back(p);
      end
   endtask

   task automatic load_frame(input int gap_every, output int last);
      last = 0;
      for (int b = 0; b < NPIX; b++) begin
         if (gap_every > 0 && b > 0 && (b % gap_every) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         exp_ifm.push_back(b);
         if (b < K * K) exp_w.push_back(b);
         bus.in_valid = 1'b1;
         last = cyc;
         if (b == 1) begin
            push_probe("err_overrun cleared on first beat", P_ERR, 0);
            push_probe("busy during load", P_BUSY, 1);
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      push_probe("conv_go right after last beat", P_CONVGO, 1);
   endtask

   task automatic wait_q(input int kind, input int target, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (sig(kind) <= target) break;
         @(posedge clk);
         #1;
      end
      push_probe(name, kind, target);
   endtask

   task automatic run_frame(input int gap_every, input int cl, input int pl, input bit hold,
                            input int ovr_win);
      int  last;
      fd_t f;
      clat      = cl;
      plat      = pl;
      hold_mode = hold;
      push_frame(NCONV, NPOOL, 1 + cl, 1 + pl);
      load_frame(gap_every, last);
      f.cyc = last + 1 + NCONV * (1 + cl) + NPOOL * (1 + pl);
      f.err = (ovr_win >= 0) ? 1 : 0;
      exp_fd.push_back(f);
      if (ovr_win >= 0) begin
         wait_q(P_QCONV, NCONV - 1 - ovr_win, 2000, "reach overrun window");
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         push_probe("err_overrun set", P_ERR, 1);
      end
      wait_q(P_QFD, 0, 3000, "frame_done reached");
      push_probe("busy low after frame", P_BUSY, 0);
   endtask

   initial begin : stimulus
      int last;
      bus.clr      = 1'b0;
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      push_probe("outputs in reset", P_ALL, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_probe("outputs idle after reset", P_ALL, 0);
      @(posedge clk);
      #1;

      // Continuous frame, done in the first wait cycle.
      run_frame(0, 1, 1, 1'b0, -1);
      // Gapped load.
      run_frame(3, 1, 1, 1'b0, -1);
      // conv_done high during ISSUE, MAC latency 5.
      run_frame(0, 5, 1, 1'b1, -1);
      // Overrun during conv window 20; flag stays through DONE and IDLE.
      run_frame(0, 1, 1, 1'b0, 20);
      push_probe("err_overrun sticky in idle", P_ERR, 1);

      // Abort at conv window 50.
      clat = 1;
      plat = 1;
      push_frame(51, 0, 2, 2);
      load_frame(0, last);
      wait_q(P_QCONV, 0, 1000, "reach clr window");
      bus.clr = 1'b1;
      @(posedge clk);
      #1;
      bus.clr = 1'b0;
      push_probe("busy low after clr", P_BUSY, 0);
      push_probe("outputs idle after clr", P_ALL, 0);
      repeat (6) @(posedge clk);
      #1;

      // Full frame after abort restarts from window 0.
      run_frame(0, 1, 1, 1'b0, -1);

      // Async reset during POOL_WAIT with err_overrun set.
      push_frame(NCONV, 11, 2, 2);
      load_frame(0, last);
      repeat (3) @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      push_probe("err_overrun set before reset", P_ERR, 1);
      wait_q(P_QPOOL, 0, 2000, "reach pool window 10");
      #1;
      rst_n = 1'b0;
      push_probe("outputs cleared by async reset", P_ALL, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      push_probe("idle after reset release", P_ALL, 0);
      @(posedge clk);
      #1;

      // Normal frame after reset.
      run_frame(0, 1, 1, 1'b0, -1);

      push_probe("conv expectations drained", P_QCONV, 0);
      push_probe("pool expectations drained", P_QPOOL, 0);
      push_probe("ifm expectations drained", P_QIFM, 0);
      push_probe("weight expectations drained", P_QW, 0);
      push_probe("frame_done expectations drained", P_QFD, 0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: time limit hit at cycle %0d, expected end of test", cyc);
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/conv_pool_scheduler.md
Name: conv_pool_scheduler

Overview:
- Control sequencer for the 14x14 IFM / 3x3 kernel convolution and 2x2 max-pool datapath.
- Steers the input stream into the IFM and weight buffers and issues one 3x3 window per conv output, handshaking with the MAC unit.
- Then issues one 2x2 pooling window per pooled output, handshaking with the pooling unit.
- Contains no arithmetic on pixel data. It generates addresses, strobes and frame status only.

Parameters:
- IMG_W, 14, IFM width and height in pixels (square image).
- K, 3, kernel width and height.
- ADDR_W, 8, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_W.
- Derived constants, not overridable: OUT_W = IMG_W-K+1 (12), NCONV = OUT_W*OUT_W (144), PW = OUT_W/2 (6), NPOOL = PW*PW (36). OUT_W must be even.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous abort; returns the block to IDLE on the next edge
- in_valid  in  1  IFM (and weight, beats 0..8) stream beat valid
- ifm_we  out  1  IFM buffer write enable (combinational)
- ifm_waddr  out  ADDR_W  IFM buffer write address (combinational = load_cnt)
- w_we  out  1  weight buffer write enable (combinational)
- w_waddr  out  4  weight buffer write address (combinational = load_cnt[3:0])
- conv_go  out  1  start one 3x3 window in the MAC
- conv_base  out  ADDR_W  IFM address of window top-left = crow*IMG_W+ccol
- ofm_idx  out  ADDR_W  OFM write index for the current window = crow*OUT_W+ccol
- conv_done  in  1  MAC result written to OFM
- pool_go  out  1  start one 2x2 pooling window
- pool_base  out  ADDR_W  OFM address of window top-left = 2*prow*OUT_W+2*pcol
- pool_done  in  1  pooled result emitted
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- err_overrun  out  1  sticky; in_valid seen outside IDLE/LOAD

Behaviour:
- FSM states: IDLE, LOAD, CONV_ISSUE, CONV_WAIT, POOL_ISSUE, POOL_WAIT, DONE. State and all counters are registered.
- Registered outputs are Moore decodes of state and counters: conv_go=(state==CONV_ISSUE), pool_go=(state==POOL_ISSUE), busy=(state!=IDLE), frame_done=(state==DONE).
- Reset values: state IDLE; load_cnt, crow, ccol, prow, pcol all 0; every output 0.
- Write decode: ifm_we = in_valid & (state IDLE or LOAD) & load_cnt<IMG_W*IMG_W. w_we = ifm_we & load_cnt<K*K.
- IDLE: in_valid -> beat 0 written this cycle; load_cnt becomes 1; err_overrun cleared; next state LOAD.
- LOAD: each in_valid beat writes and increments load_cnt. Gaps (in_valid=0) hold all state. The beat with load_cnt=195 moves to CONV_ISSUE; load_cnt clears.
- CONV_ISSUE: lasts exactly 1 cycle, then CONV_WAIT. conv_done is ignored in this state.
- CONV_WAIT: hold until conv_done=1. Then:
  - ccol increments; at OUT_W-1 it wraps to 0 and crow increments.
  - If ofm_idx==NCONV-1, go to POOL_ISSUE with crow/ccol cleared; otherwise go to CONV_ISSUE.
- POOL_ISSUE / POOL_WAIT: same pattern with pool_done, pcol/prow wrapping at PW-1. After pooled output NPOOL-1, go to DONE.
- DONE: 1 cycle, then IDLE.
- in_valid in CONV_*, POOL_* or DONE: no write, err_overrun <= 1 (sticky until the next IDLE->LOAD).
- clr: highest priority after reset. Next state IDLE; counters 0; err_overrun held; no frame_done pulse.
- rst_n low mid-frame: immediate return to reset values, including err_overrun=0.
- Minimum throughput: 2 cycles per conv output and 2 per pool output.

Test Plan:
- Continuous frame, done pulsed in the first WAIT cycle -> exactly 196 ifm_we and 9 w_we (waddr 0..8); 144 conv_go with conv_base 0,1..11,14,..,165; 36 pool_go with pool_base 0,2..10,24,..,130; frame_done exactly 196+288+72 cycles after the first beat.
- in_valid with 1-cycle gaps every 3rd beat -> addresses contiguous 0..195 with no skips; CONV_ISSUE entered the cycle after beat 195.
- conv_done held high through CONV_ISSUE and MAC latency 5 -> no index advances on the ISSUE cycle; each conv_go is 1 cycle wide, spaced 6 cycles.
- in_valid pulsed during conv window 20 -> err_overrun=1 and remains 1 through DONE; no ifm_we; cleared by the next frame's first beat.
- clr at conv window 50 -> IDLE next cycle, busy=0, no frame_done. A following full frame completes correctly with conv_base restarting at 0.
- rst_n low during POOL_WAIT -> all outputs 0 asynchronously; after release, in_valid starts a normal frame.
